// File: rtl/udma_tx_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : udma_tx_checker
// Brief    : Sinks a uDMA TX linear channel and checks the returned words
//            against an incrementing pattern; status is read back over cfg.
// Revision : 1.0 - initial release
// ============================================================================
module udma_tx_checker #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int DATA_W          = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       udma_cfg_data_i,
    output logic [31:0]       udma_cfg_data_o,
    output logic              udma_tx_lin_req_o,
    input  logic              udma_tx_lin_gnt_i,
    input  logic              udma_tx_lin_valid_i,
    input  logic [DATA_W-1:0] udma_tx_lin_data_i,
    output logic              udma_tx_lin_ready_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] C_MAX_OUT = 4'(MAX_OUTSTANDING);

    state_t            r_state;
    logic [DATA_W-1:0] r_expected;
    logic [8:0]        r_issued;
    logic [8:0]        r_received;
    logic [3:0]        r_outstanding;
    logic              r_toggle;
    logic              r_mismatch;
    logic              r_proto_err;
    logic [7:0]        r_err_cnt;
    logic [7:0]        r_first_idx;

    logic              w_enable;
    logic              w_throttle;
    logic [8:0]        w_target;
    logic [DATA_W-1:0] w_init;
    logic              w_req;
    logic              w_ready;
    logic              w_grant;
    logic              w_accept;
    logic              w_proto;
    logic              w_take;
    logic              w_bad_word;
    logic              w_unused_cfg;

    assign w_enable     = udma_cfg_data_i[0];
    assign w_throttle   = udma_cfg_data_i[1];
    assign w_unused_cfg = ^udma_cfg_data_i[7:2];
    // A programmed count of zero selects the full 256-word transfer.
    assign w_target     = (udma_cfg_data_i[15:8] == 8'd0) ? 9'd256 : {1'b0, udma_cfg_data_i[15:8]};
    assign w_init       = DATA_W'(udma_cfg_data_i[31:16]);

    assign w_req      = (r_state == S_RUN) && (r_issued < w_target) && (r_outstanding < C_MAX_OUT);
    assign w_ready    = (r_state == S_RUN) && (!w_throttle || r_toggle);
    assign w_grant    = w_req && udma_tx_lin_gnt_i;
    assign w_accept   = udma_tx_lin_valid_i && w_ready;
    // Data arriving with nothing outstanding is swallowed and only flagged.
    assign w_proto    = w_accept && (r_outstanding == 4'd0);
    assign w_take     = w_accept && !w_proto;
    assign w_bad_word = w_take && (udma_tx_lin_data_i != r_expected);

    assign udma_tx_lin_req_o   = w_req;
    assign udma_tx_lin_ready_o = w_ready;
    assign udma_cfg_data_o     = {r_received[7:0], r_first_idx, r_err_cnt, 4'b0000,
                                  r_proto_err, r_mismatch, (r_state == S_DONE), (r_state == S_RUN)};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_expected    <= '0;
            r_issued      <= '0;
            r_received    <= '0;
            r_outstanding <= '0;
            r_toggle      <= 1'b0;
            r_mismatch    <= 1'b0;
            r_proto_err   <= 1'b0;
            r_err_cnt     <= '0;
            r_first_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_enable) begin
                        r_state       <= S_RUN;
                        r_expected    <= w_init;
                        r_issued      <= '0;
                        r_received    <= '0;
                        r_outstanding <= '0;
                        r_toggle      <= 1'b0;
                        r_mismatch    <= 1'b0;
                        r_proto_err   <= 1'b0;
                        r_err_cnt     <= '0;
                        r_first_idx   <= '0;
                    end
                end
                S_RUN: begin
                    if (!w_enable) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_toggle <= ~r_toggle;
                        if (w_grant) begin
                            r_issued <= r_issued + 9'd1;
                        end
                        if (w_grant && !w_take) begin
                            r_outstanding <= r_outstanding + 4'd1;
                        end else if (!w_grant && w_take) begin
                            r_outstanding <= r_outstanding - 4'd1;
                        end
                        if (w_proto) begin
                            r_proto_err <= 1'b1;
                        end
                        if (w_take) begin
                            r_expected <= r_expected + 1'b1;
                            r_received <= r_received + 9'd1;
                            if (w_bad_word) begin
                                r_mismatch <= 1'b1;
                                if (r_err_cnt != 8'hFF) begin
                                    r_err_cnt <= r_err_cnt + 8'd1;
                                end
                                if (!r_mismatch) begin
                                    r_first_idx <= r_received[7:0];
                                end
                            end
                            if (r_received == (w_target - 9'd1)) begin
                                r_state <= S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (!w_enable) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_udma_tx_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_udma_tx_checker
// Brief    : Table-driven, hand-sequenced and randomized checks of udma_tx_checker
//            against a memory model and a transfer-level status model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_udma_tx_checker;

    localparam int C_MAX_OUT = 4;
    localparam int C_DW      = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     cfg_in;
    logic [31:0]     cfg_out;
    logic            req;
    logic            gnt;
    logic            valid;
    logic            ready;
    logic [C_DW-1:0] data;

    int vectors = 0;
    int errors  = 0;

    bit          corrupt [256];
    logic [31:0] bad_val [256];

    typedef struct {
        int          ncfg;
        logic [15:0] init;
        bit          thr;
        int          lat;
        int          gnt_pct;
        int          bad_idx;     // -1 none, -2 every word, else one index
        logic [31:0] exp_status;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    udma_tx_checker #(
        .MAX_OUTSTANDING (C_MAX_OUT),
        .DATA_W          (C_DW)
    ) u_dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .udma_cfg_data_i     (cfg_in),
        .udma_cfg_data_o     (cfg_out),
        .udma_tx_lin_req_o   (req),
        .udma_tx_lin_gnt_i   (gnt),
        .udma_tx_lin_valid_i (valid),
        .udma_tx_lin_data_i  (data),
        .udma_tx_lin_ready_o (ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [15:0] init, input int i);
        logic [31:0] good;
        good = 32'(init) + 32'(i);
        return corrupt[i] ? bad_val[i] : good;
    endfunction

    // Status after a completed transfer, derived from the corruption pattern only.
    function automatic logic [31:0] model_status(input int ncfg);
        int n;
        int errs;
        int first;
        bit seen;
        n = (ncfg == 0) ? 256 : ncfg;
        errs = 0;
        first = 0;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (corrupt[i]) begin
                if (!seen) first = i;
                seen = 1'b1;
                errs++;
            end
        end
        if (errs > 255) errs = 255;
        return {8'(n % 256), 8'(first), 8'(errs), 4'b0000, 1'b0, seen, 1'b1, 1'b0};
    endfunction

    task automatic clear_corrupt();
        for (int i = 0; i < 256; i++) begin
            corrupt[i] = 1'b0;
            bad_val[i] = '0;
        end
    endtask

    // Memory model: each grant returns its word after lat cycles, in order.
    task automatic run_xfer(input int ncfg, input logic [15:0] init, input bit thr, input int lat,
                            input int gnt_pct, output logic [31:0] status, output int max_out);
        int n;
        int grants;
        int accepts;
        int cyc;
        int avail_q[$];
        bit hs_g;
        bit hs_a;
        n = (ncfg == 0) ? 256 : ncfg;
        grants = 0;
        accepts = 0;
        cyc = 0;
        max_out = 0;
        gnt = 1'b0;
        valid = 1'b0;
        cfg_in = {init, 8'(ncfg), 6'b000000, thr, 1'b1};
        @(posedge clk); #1;
        while (accepts < n && cyc < 5000) begin
            check("req", 32'(req), 32'((grants < n) && (grants - accepts < C_MAX_OUT)));
            check("ready", 32'(ready), 32'(!thr || (cyc % 2 == 1)));
            check("busy", 32'(cfg_out[0]), 32'd1);
            gnt   = ($urandom_range(99) < gnt_pct);
            valid = (avail_q.size() > 0) && (avail_q[0] <= cyc);
            data  = valid ? word_at(init, accepts) : $urandom;
            hs_g  = req && gnt;
            hs_a  = valid && ready;
            @(posedge clk); #1;
            cyc++;
            if (hs_a) begin
                void'(avail_q.pop_front());
                accepts++;
            end
            if (hs_g) begin
                avail_q.push_back(cyc - 1 + lat);
                grants++;
            end
            if (grants - accepts > max_out) max_out = grants - accepts;
        end
        if (cyc >= 5000) check("timeout", 32'(accepts), 32'(n));
        gnt = 1'b0;
        valid = 1'b0;
        status = cfg_out;
        check("grants", 32'(grants), 32'(n));
        check("done_req", {30'd0, req, ready}, 32'd0);
        cfg_in[0] = 1'b0;
        @(posedge clk); #1;
        check("idle_after_done", cfg_out, status & ~32'h2);
    endtask

    initial begin
        logic [31:0] st;
        int          mo;
        int          nr;

        tbl[0] = '{ncfg: 4, init: 16'h0010, thr: 1'b0, lat: 1,  gnt_pct: 100, bad_idx: -1, exp_status: 32'h04000002};
        tbl[1] = '{ncfg: 8, init: 16'h1234, thr: 1'b0, lat: 1,  gnt_pct: 100, bad_idx: 2,  exp_status: 32'h08020106};
        tbl[2] = '{ncfg: 0, init: 16'hFFFF, thr: 1'b1, lat: 1,  gnt_pct: 100, bad_idx: -1, exp_status: 32'h00000002};
        tbl[3] = '{ncfg: 8, init: 16'h0000, thr: 1'b0, lat: 10, gnt_pct: 100, bad_idx: -1, exp_status: 32'h08000002};
        tbl[4] = '{ncfg: 1, init: 16'hABCD, thr: 1'b0, lat: 3,  gnt_pct: 50,  bad_idx: -1, exp_status: 32'h01000002};
        tbl[5] = '{ncfg: 0, init: 16'h0000, thr: 1'b1, lat: 2,  gnt_pct: 70,  bad_idx: -2, exp_status: 32'h0000FF06};

        rst = 1'b1;
        cfg_in = '0;
        gnt = 1'b0;
        valid = 1'b0;
        data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_status", cfg_out, 32'd0);
        check("reset_req", 32'(req), 32'd0);
        check("reset_ready", 32'(ready), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 6; t++) begin
            clear_corrupt();
            if (tbl[t].bad_idx == -2) begin
                for (int i = 0; i < 256; i++) begin
                    corrupt[i] = 1'b1;
                    bad_val[i] = (32'(tbl[t].init) + 32'(i)) ^ 32'h1;
                end
            end else if (tbl[t].bad_idx >= 0) begin
                corrupt[tbl[t].bad_idx] = 1'b1;
                bad_val[tbl[t].bad_idx] = 32'h0000DEAD;
            end
            run_xfer(tbl[t].ncfg, tbl[t].init, tbl[t].thr, tbl[t].lat, tbl[t].gnt_pct, st, mo);
            check($sformatf("table%0d_status", t), st, tbl[t].exp_status);
            if (tbl[t].lat == 10) check("max_outstanding", 32'(mo), 32'(C_MAX_OUT));
        end

        // Spurious data before any grant, then abort after two words.
        cfg_in = {16'h0000, 8'd6, 6'b000000, 1'b0, 1'b1};
        @(posedge clk); #1;
        valid = 1'b1;
        data = 32'h55;
        @(posedge clk); #1;
        valid = 1'b0;
        check("proto_err", cfg_out, 32'h00000009);
        check("proto_req", 32'(req), 32'd1);
        gnt = 1'b1;
        @(posedge clk); #1;
        valid = 1'b1;
        data = 32'd0;
        @(posedge clk); #1;
        gnt = 1'b0;
        data = 32'd1;
        @(posedge clk); #1;
        valid = 1'b0;
        check("mid_run", cfg_out, 32'h02000009);
        cfg_in[0] = 1'b0;
        @(posedge clk); #1;
        check("abort_status", cfg_out, 32'h02000008);
        check("abort_req_ready", {30'd0, req, ready}, 32'd0);
        valid = 1'b1;
        data = 32'd2;
        @(posedge clk); #1;
        valid = 1'b0;
        check("abort_late_data", cfg_out, 32'h02000008);

        // Reset with three grants outstanding, then a clean short run.
        cfg_in = {16'h0000, 8'd8, 6'b000000, 1'b0, 1'b1};
        @(posedge clk); #1;
        gnt = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        gnt = 1'b0;
        check("pre_reset_status", cfg_out, 32'h00000001);
        check("pre_reset_req", 32'(req), 32'd1);
        rst = 1'b1;
        cfg_in = '0;
        @(posedge clk); #1;
        check("mid_reset_status", cfg_out, 32'd0);
        check("mid_reset_req_ready", {30'd0, req, ready}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        clear_corrupt();
        run_xfer(2, 16'h0007, 1'b0, 1, 100, st, mo);
        check("post_reset_run", st, 32'h02000002);

        for (int r = 0; r < 8; r++) begin
            logic [15:0] init;
            clear_corrupt();
            nr   = $urandom_range(1, 40);
            init = 16'($urandom);
            for (int i = 0; i < nr; i++) begin
                if ($urandom_range(5) == 0) begin
                    corrupt[i] = 1'b1;
                    bad_val[i] = (32'(init) + 32'(i)) ^ (32'h1 << $urandom_range(31));
                end
            end
            run_xfer(nr, init, 1'($urandom_range(1)), $urandom_range(1, 6), $urandom_range(30, 100), st, mo);
            check($sformatf("random%0d_status", r), st, model_status(nr));
            if (mo > C_MAX_OUT) check("random_outstanding", 32'(mo), 32'(C_MAX_OUT));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
